// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between fetch (IF) and data (DM).
// Optional perf counters enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic [31:0] i_dm_addr,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_ready,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_if_grants,
  output logic [31:0] o_perf_dm_grants,
  output logic [31:0] o_perf_if_stall_cycles
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {
    OWN_NONE, OWN_IF, OWN_DM
  } owner_t;

  localparam logic [3:0] MAX_S = 4'(MAX_DM_STREAK);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        dm_win, if_win, accept;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    o_if_ready  = 1'b0;
    o_dm_ready  = 1'b0;
    accept      = 1'b0;
    dm_win = i_dm_req && !(i_if_req && streak_q == MAX_S);
    if_win = !dm_win && i_if_req;
    unique case (state_q)
      S_IDLE: begin
        // Gated by reset so the port is silent while held in reset
        if (i_rst_n) begin
          o_mem_req = dm_win || if_win;
          if (dm_win) begin
            o_mem_addr  = i_dm_addr & 32'hFFFF_FFFC;
            o_mem_wen   = i_dm_wen;
            o_mem_wdata = i_dm_wdata;
            o_mem_mask  = i_dm_mask;
          end else if (if_win) begin
            o_mem_addr  = i_if_addr & 32'hFFFF_FFFC;
            o_mem_mask  = 4'b1111;
          end
          accept = o_mem_req && i_mem_ready;
        end
        o_dm_ready = accept && dm_win;
        o_if_ready = accept && if_win;
        if (accept) begin
          state_d = S_WAIT;
          owner_d = dm_win ? OWN_DM : OWN_IF;
          if (dm_win && i_if_req)
            streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
          else
            streak_d = 4'd0;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = i_mem_rdata;
          end
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = i_mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_dm_rvalid = dm_rvalid_q;
  assign o_dm_rdata  = dm_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pf_if_q, pf_if_d;
  logic [31:0] pf_dm_q, pf_dm_d;
  logic [31:0] pf_st_q, pf_st_d;

  always_comb begin
    pf_if_d = pf_if_q + 32'(o_if_ready);
    pf_dm_d = pf_dm_q + 32'(o_dm_ready);
    pf_st_d = pf_st_q + 32'(i_if_req && !o_if_ready);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pf_if_q <= '0;
      pf_dm_q <= '0;
      pf_st_q <= '0;
    end else begin
      pf_if_q <= pf_if_d;
      pf_dm_q <= pf_dm_d;
      pf_st_q <= pf_st_d;
    end
  end

  assign o_perf_if_grants       = pf_if_q;
  assign o_perf_dm_grants       = pf_dm_q;
  assign o_perf_if_stall_cycles = pf_st_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port between the hart's instruction-fetch requester (IF) and its data-memory requester (DM).
- Sits between the hart and the realistic memory model that replaces the combinational imem/dmem ports.
- Enforces one outstanding transaction at a time. DM has priority; a streak limit prevents fetch starvation.
- Routes each response back to the requester that owns the outstanding transaction.

Parameters:
- MAX_DM_STREAK, 4: maximum consecutive DM grants while IF is waiting; the next grant is forced to IF. Legal range is 1..15.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request valid
- i_if_addr  in  32  fetch address
- o_if_ready  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch data valid, one-cycle pulse
- o_if_rdata  out  32  fetched instruction word
- i_dm_req  in  1  data request valid
- i_dm_addr  in  32  data address
- i_dm_wen  in  1  1 = store, 0 = load
- i_dm_wdata  in  32  store data
- i_dm_mask  in  4  byte-lane mask
- o_dm_ready  out  1  data request accepted this cycle
- o_dm_rvalid  out  1  load data valid / store complete, one-cycle pulse
- o_dm_rdata  out  32  load word
- o_mem_req  out  1  request to memory
- o_mem_addr  out  32  word-aligned address
- o_mem_wen  out  1  write enable
- o_mem_wdata  out  32  write data
- o_mem_mask  out  4  byte-lane mask
- i_mem_ready  in  1  memory accepts request this cycle
- i_mem_rvalid  in  1  memory response valid
- i_mem_rdata  in  32  memory read data

Behaviour:
- Reset:
  - Asynchronous on i_rst_n low.
  - State = IDLE, owner = none, streak = 0.
  - All o_* outputs = 0.
- Requesters must hold req, addr and data stable until they see ready.
- State IDLE, winner selection (combinational):
  - DM wins if i_dm_req && !(i_if_req && streak == MAX_DM_STREAK).
  - Otherwise IF wins if i_if_req.
  - Otherwise there is no winner.
- IDLE, memory drive:
  - o_mem_req = winner present.
  - o_mem_addr = winner address with bits [1:0] forced to 0.
  - IF winner: wen = 0, mask = 4'b1111, wdata = 0.
  - DM winner: i_dm_wen, i_dm_wdata and i_dm_mask pass through.
- IDLE, on i_mem_ready && o_mem_req:
  - The winner's ready pulses for 1 cycle (combinational).
  - Owner is latched and the next state is WAIT.
  - Streak update:
    - DM grant with i_if_req high: streak + 1, saturating.
    - DM grant with IF idle: streak = 0.
    - IF grant: streak = 0.
- WAIT:
  - o_mem_req = 0; both ready outputs = 0.
  - On i_mem_rvalid, the owner's rvalid pulses 1 cycle with rdata = i_mem_rdata; next state is IDLE.
  - The next grant comes no earlier than the following cycle, so accept-to-accept spacing is at least 2 cycles.
- Response outputs:
  - Minimum request-to-response latency is 1 cycle after acceptance.
  - rvalid/rdata are registered: the owner sees them on the cycle after i_mem_rvalid.
  - The non-owner's rvalid is always 0.
  - rdata holds its last value when rvalid = 0.
- i_mem_rvalid while in IDLE: ignored, covering stale responses after reset. No state change.
- Simultaneous IF and DM requests below the streak limit: DM wins, IF waits and its ready stays 0.
- Reset in WAIT: the transaction is dropped with no rvalid to either requester; the arbiter returns to IDLE.
- Stores complete via o_dm_rvalid; o_dm_rdata is don't-care for stores.
- i_mem_ready low in IDLE: memory signals stay driven from the current winner. The winner may change if a higher-priority request arrives.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Enabled:
  - Adds 32-bit outputs o_perf_if_grants, o_perf_dm_grants and o_perf_if_stall_cycles.
  - o_perf_if_stall_cycles counts cycles with i_if_req high and o_if_ready low.
  - All counters wrap at 2^32 and reset to 0.
- Disabled: the ports and counters are absent; core behaviour is identical.

Test Plan:
- IF-only fetch at 0x00000104, memory ready immediately, rvalid 2 cycles later with 0x00000013:
  - o_mem_addr = 0x00000104, mask = 4'b1111, o_if_ready pulses.
  - o_if_rvalid = 1 with rdata 0x00000013 one cycle after i_mem_rvalid.
  - o_dm_rvalid stays 0.
- IF and DM request in the same cycle, DM load at 0x00002003 mask 4'b1000:
  - DM is granted first with o_mem_addr = 0x00002000.
  - IF is granted in the first IDLE cycle after the DM response.
- DM requests continuously with IF pending, MAX_DM_STREAK = 4:
  - Grant order is exactly D, D, D, D, I, D.
  - Streak reads 0 after the IF grant.
- DM store at 0x00003000 with data 0xDEADBEEF, i_mem_ready delayed 3 cycles:
  - o_mem_wen = 1 held stable for those cycles; o_dm_ready pulses only on the accept cycle.
  - o_dm_rvalid pulses after i_mem_rvalid.
- i_rst_n asserted during WAIT:
  - All outputs drop to 0 asynchronously.
  - A late i_mem_rvalid after release produces no rvalid to either requester.
  - A new IF request is then served normally.
- With MEM_ARB_PERF_CNT_EN defined, run the streak scenario:
  - o_perf_dm_grants = 5, o_perf_if_grants = 1.
  - o_perf_if_stall_cycles equals the cycles counted from IF assert to o_if_ready.
